hex7seg_scan: RTL

- Time-multiplexed driver for an N-digit common-anode seven-segment display; generalises the single-digit hex decoder to NUM_DIGITS digits sharing one segment bus.
- Latches a packed hex word on load, cycles the anodes with a programmable refresh period and a ghosting guard interval, and supports per-digit blanking, decimal points and leading-zero suppression.
- Sits between the datapath and board display pins; all outputs are registered.

---
 rtl/hex7seg_pkg.sv | 35 +++
 rtl/hex7seg_scan_timer.sv | 52 +++++
 rtl/hex7seg_scan.sv | 98 +++++++++
 3 files changed

// File: rtl/hex7seg_pkg.sv
// rtl/hex7seg_pkg.sv - shared types and nibble-to-segment table for the scanned hex display
package hex7seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Active-high segment pattern {A,B,C,D,E,F,G}, A in the MSB.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg_scan_timer.sv
// rtl/hex7seg_scan_timer.sv - GUARD/DRIVE scan sequencer with per-state cycle counter and digit index
module hex7seg_scan_timer
    import hex7seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 8,
    parameter int IDX_W        = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [IDX_W-1:0] idx,
    output state_e           state_nxt,
    output logic [IDX_W-1:0] idx_nxt
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        if (state == GUARD) begin
            if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
            end
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            state_nxt = GUARD;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

endmodule

// File: rtl/hex7seg_scan.sv
// rtl/hex7seg_scan.sv - time-multiplexed N-digit seven-segment driver with blanking, dp and zero suppression
module hex7seg_scan
    import hex7seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 8,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lz_suppress_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [IDX_W-1:0]        digit_idx_o
);

    logic [4*NUM_DIGITS-1:0] data_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;

    state_e                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;

    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   dark;
    logic [3:0]              nib;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_nxt;
    seg_t                    seg_nxt;
    logic                    dp_nxt;

    hex7seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (idx),
        .state_nxt (state_nxt),
        .idx_nxt   (idx_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_sh  <= '0;
            blank_sh <= '0;
            dp_sh    <= '0;
        end else if (load_i) begin
            data_sh  <= data_i;
            blank_sh <= blank_i;
            dp_sh    <= dp_i;
        end
    end

    // lead_zero[k]: nibbles k..NUM_DIGITS-1 are all zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (data_sh[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
    end

    assign dark    = blank_sh | (lz_suppress_i ? (lead_zero & ~NUM_DIGITS'(1)) : '0);
    assign nib     = data_sh[{idx_nxt, 2'b00} +: 4];
    assign lit     = (state_nxt == DRIVE) && !dark[idx_nxt];
    assign an_nxt  = lit ? (NUM_DIGITS'(1) << idx_nxt) : '0;
    assign seg_nxt = lit ? hex_to_seg(nib) : '0;
    assign dp_nxt  = lit & dp_sh[idx_nxt];

    // Registered from next-state so the pins line up exactly with the timer state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_o  <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_o <= {7{ACTIVE_LOW}};
            dp_o  <= ACTIVE_LOW;
        end else begin
            an_o  <= an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_o <= seg_nxt ^ {7{ACTIVE_LOW}};
            dp_o  <= dp_nxt ^ ACTIVE_LOW;
        end
    end

    assign digit_idx_o = idx;

endmodule
